// File: rtl/egress_lector_if.sv
// Egress reader bus: FIFO pop/read side, merged valid/ready output and status.
// master = the reader, slave = FIFOs plus downstream consumer.
interface egress_lector_if #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 6
);
  logic                 enable;
  logic                 empty_e0;
  logic                 empty_e1;
  logic [DATA_SIZE-1:0] data_e0;
  logic [DATA_SIZE-1:0] data_e1;
  logic                 pop_e0;
  logic                 pop_e1;
  logic                 ready_in;
  logic                 valid_out;
  logic [DATA_SIZE-1:0] data_out;
  logic                 dest_out;
  logic [CNT_SIZE-1:0]  cnt_e0;
  logic [CNT_SIZE-1:0]  cnt_e1;
  logic                 idle;

  modport master (
    input  enable, empty_e0, empty_e1, data_e0, data_e1, ready_in,
    output pop_e0, pop_e1, valid_out, data_out, dest_out, cnt_e0, cnt_e1, idle
  );

  modport slave (
    output enable, empty_e0, empty_e1, data_e0, data_e1, ready_in,
    input  pop_e0, pop_e1, valid_out, data_out, dest_out, cnt_e0, cnt_e1, idle
  );
endinterface

// File: rtl/egress_lector.sv
// Drains two egress FIFOs with round-robin pops, captures read data one cycle
// later into a 2-entry skid buffer, and tags each word with its source port.
//
// state | meaning
// OCC_0 | skid buffer empty
// OCC_1 | one word held (head in slot 0)
// OCC_2 | two words held, no further pop until one leaves
module egress_lector #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 6
) (
  input  logic           clk,
  input  logic           reset,
  egress_lector_if.master bus
);

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_t;

  occ_t                 occ;
  occ_t                 occ_nxt;
  logic                 inflight;
  logic                 inflight_src;
  logic                 rr_ptr;
  logic                 rr_ptr_nxt;
  logic [DATA_SIZE-1:0] buf_data [2];
  logic [1:0]           buf_dest;
  logic [CNT_SIZE-1:0]  cnt_e0_q;
  logic [CNT_SIZE-1:0]  cnt_e1_q;

  logic                 deq;
  logic [2:0]           load;
  logic [2:0]           limit;
  logic                 budget_ok;
  logic                 elig0;
  logic                 elig1;
  logic                 grant0;
  logic                 grant1;
  logic                 wr_idx;
  logic [DATA_SIZE-1:0] cap_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ          <= OCC_0;
      inflight     <= 1'b0;
      inflight_src <= 1'b0;
      rr_ptr       <= 1'b0;
    end else begin
      occ          <= occ_nxt;
      inflight     <= grant0 | grant1;
      inflight_src <= grant1;
      rr_ptr       <= rr_ptr_nxt;
    end
  end

  always_comb begin
    deq        = (occ != OCC_0) & bus.ready_in;
    load       = {1'b0, occ} + {2'b00, inflight};
    limit      = 3'd2 + {2'b00, deq};
    // pops are gated by reset so the strobes are low while reset is held
    budget_ok  = ~reset & bus.enable & (load < limit);
    elig0      = budget_ok & ~bus.empty_e0;
    elig1      = budget_ok & ~bus.empty_e1;
    grant0     = 1'b0;
    grant1     = 1'b0;
    rr_ptr_nxt = rr_ptr;
    if (elig0 & elig1) begin
      grant0     = ~rr_ptr;
      grant1     = rr_ptr;
      rr_ptr_nxt = ~rr_ptr;
    end else if (elig0) begin
      grant0     = 1'b1;
      rr_ptr_nxt = 1'b1;
    end else if (elig1) begin
      grant1     = 1'b1;
      rr_ptr_nxt = 1'b0;
    end

    occ_nxt = occ;
    case ({inflight, deq})
      2'b10:   occ_nxt = (occ == OCC_0) ? OCC_1 : OCC_2;
      2'b01:   occ_nxt = (occ == OCC_2) ? OCC_1 : OCC_0;
      default: occ_nxt = occ;
    endcase

    // tail slot seen after this cycle's dequeue shift
    wr_idx   = (occ == OCC_2) | ((occ == OCC_1) & ~deq);
    cap_data = inflight_src ? bus.data_e1 : bus.data_e0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_dest    <= 2'b00;
    end else begin
      if (deq) begin
        buf_data[0] <= buf_data[1];
        buf_dest[0] <= buf_dest[1];
      end
      if (inflight) begin
        buf_data[wr_idx] <= cap_data;
        buf_dest[wr_idx] <= inflight_src;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_e0_q <= '0;
      cnt_e1_q <= '0;
    end else if (inflight) begin
      if (inflight_src) cnt_e1_q <= cnt_e1_q + 1'b1;
      else              cnt_e0_q <= cnt_e0_q + 1'b1;
    end
  end

  assign bus.pop_e0    = grant0;
  assign bus.pop_e1    = grant1;
  assign bus.valid_out = (occ != OCC_0);
  assign bus.data_out  = buf_data[0];
  assign bus.dest_out  = buf_dest[0];
  assign bus.cnt_e0    = cnt_e0_q;
  assign bus.cnt_e1    = cnt_e1_q;
  assign bus.idle      = (occ == OCC_0) & ~inflight;

endmodule

// File: doc/egress_lector.md
# egress_lector

Egress reader for the two-destination classification switch: drains the two egress FIFOs (E0, E1) by generating their pop strobes, and captures the read data one cycle later. It merges both streams onto a single valid/ready output with a destination tag and a 2-entry skid buffer. Fair round-robin arbitration is used when both FIFOs hold data. It also keeps per-port word counters for scoreboard comparison against the ingress side.

## Interface
Parameters:
- DATA_SIZE, 8, width of FIFO words and data_out
- CNT_SIZE, 6, width of per-port received-word counters (wrap modulo 2^CNT_SIZE)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- enable  in  1  1 = reader may issue pops; 0 = no new pops (in-flight word still captured)
- empty_e0  in  1  egress FIFO 0 empty flag
- empty_e1  in  1  egress FIFO 1 empty flag
- data_e0  in  DATA_SIZE  FIFO 0 read data, valid the cycle after pop_e0
- data_e1  in  DATA_SIZE  FIFO 1 read data, valid the cycle after pop_e1
- pop_e0  out  1  pop strobe to FIFO 0 (combinational from state and inputs)
- pop_e1  out  1  pop strobe to FIFO 1
- ready_in  in  1  downstream can accept data_out this cycle
- valid_out  out  1  data_out/dest_out hold a word
- data_out  out  DATA_SIZE  head word of skid buffer
- dest_out  out  1  source port of head word (0 = E0, 1 = E1)
- cnt_e0  out  CNT_SIZE  words captured from E0 since reset
- cnt_e1  out  CNT_SIZE  words captured from E1 since reset
- idle  out  1  buffer empty and no pop in flight

## Operation
- State: occ (0..2 entries in the skid buffer, FIFO order), inflight (1 bit), inflight_src (1 bit), rr_ptr (1 bit, port with priority), cnt_e0, cnt_e1.
- deq = valid_out & ready_in. Pop budget: a pop may issue only if occ + inflight − deq < 2.
- Candidates: port k is eligible iff enable=1, empty_ek=0, and budget is available.
- Arbitration: if both ports are eligible, grant rr_ptr and then toggle rr_ptr. If one port is eligible, grant it; rr_ptr := the other port. If neither is eligible, rr_ptr is unchanged.
- At most one of pop_e0/pop_e1 is high per cycle. A pop is never issued to an empty FIFO.
- Capture: when inflight=1, data_e[inflight_src] is written at the buffer tail with dest = inflight_src. cnt_e[src] increments in the same cycle.
- Simultaneous capture and deq: the head is removed and the new word is appended. occ is unchanged, and order is preserved.
- The capture of the in-flight word completes even if enable drops or ready_in=0. The budget guarantees there is space.
- idle = (occ==0) & (inflight==0).
- Counters wrap: 2^CNT_SIZE−1 + 1 → 0, with no saturation or flag.

## Timing
- Reset values (asserted asynchronously, held while reset=1):
  - pop_e0=0, pop_e1=0
  - valid_out=0, data_out=0, dest_out=0
  - cnt_e0=0, cnt_e1=0
  - occ=0, inflight=0, rr_ptr=0, idle=1
- Reset mid-operation: buffered and in-flight words are discarded. FIFO data returned for a pop issued in the cycle before reset is ignored.
- Read latency: pop in cycle N → captured at edge ending N+1 → valid_out=1 in cycle N+2 if the buffer was empty.
- Throughput: one word per cycle sustained while ready_in=1 and any FIFO is non-empty.
- Backpressure: with ready_in=0, at most 2 words are held. Pops stop once occ + inflight = 2.
- data_out/dest_out are stable while valid_out=1 and ready_in=0.
- empty_e* is sampled in the same cycle as the pop decision. The FIFO must deassert empty only for readable data.

## Test plan
- **Reset:**
  - Stimulus: assert reset mid-stream with occ=2.
  - Required: all outputs go to their reset values immediately, without waiting for a clock edge.
  - After release with both FIFOs empty: idle=1 and no pops.
- **Single port stream:**
  - Stimulus: E0 holds 0x11, 0x22, 0x33; E1 empty; ready_in=1.
  - Required: pop_e0 high for 3 consecutive cycles.
  - data_out = 0x11, 0x22, 0x33 on consecutive cycles with dest_out=0.
  - Final counts: cnt_e0=3, cnt_e1=0.
- **Round-robin:**
  - Stimulus: E0 holds A0..A3, E1 holds B0..B3, both non-empty, ready_in=1.
  - Required output order: A0, B0, A1, B1, A2, B2, A3, B3.
  - Final counts: cnt_e0=4, cnt_e1=4.
- **Backpressure:**
  - Stimulus: ready_in=0 with 5 words in E1.
  - Required: exactly 2 pops, then valid_out=1 with data held stable.
  - Stimulus: raise ready_in.
  - Required: remaining 3 words pop and all 5 are delivered in order.
- **Enable drop with pop in flight:**
  - Stimulus: drop enable in the cycle after a pop.
  - Required: that word is still captured, no further pops occur, and idle=1 once it is dequeued.
- **Counter wrap:**
  - Stimulus: push 64 words through E0 with CNT_SIZE=6.
  - Required: cnt_e0 returns to 0; the 65th word gives cnt_e0=1.
